term_writer: RTL and testbench

TERM_WRITER -- requirements
Module: term_writer

---
 rtl/term_writer.sv | 206 ++++++++++++++++++++
 tb/tb_term_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_writer.sv
// term_writer: character-stream front end for a ROWS x COLS character plane.
// Accepts one character per IDLE cycle and turns it into registered write
// pulses on the plane port while tracking a text cursor.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   in_data, in_valid, in_ready   character input handshake (in_ready = IDLE)
//   plane_data/row/col/we         registered plane write port
//   plane_push_up                 scroll request, only together with plane_we
//   cursor_row, cursor_col        current cursor position
//   busy                          high whenever not IDLE
//
// Build option
//   TERM_BACKSPACE_EN  defined: 0x08 moves the cursor back and blanks that cell.
//                      undefined: 0x08 is accepted and dropped.
module term_writer #(
  parameter int         ROWS  = 15,
  parameter int         COLS  = 40,
  parameter logic [7:0] BLANK = 8'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] plane_data,
  output logic [3:0] plane_row,
  output logic [5:0] plane_col,
  output logic       plane_we,
  output logic       plane_push_up,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic       busy
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [7:0] CHAR_NL  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_FF  = 8'h0C;

  typedef enum logic [1:0] {IDLE, WRITE, SCROLL, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [3:0] cur_row_q, cur_row_d;
  logic [5:0] cur_col_q, cur_col_d;
  // Set for printable writes; cleared for the backspace blanking write,
  // which must leave the cursor where it is.
  logic       adv_q, adv_d;
  logic       pl_we_q, pl_we_d;
  logic       pl_push_q, pl_push_d;
  logic [7:0] pl_data_q, pl_data_d;
  logic [3:0] pl_row_q, pl_row_d;
  logic [5:0] pl_col_q, pl_col_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_row_q <= '0;
      cur_col_q <= '0;
      adv_q     <= 1'b0;
      pl_we_q   <= 1'b0;
      pl_push_q <= 1'b0;
      pl_data_q <= BLANK;
      pl_row_q  <= '0;
      pl_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      adv_q     <= adv_d;
      pl_we_q   <= pl_we_d;
      pl_push_q <= pl_push_d;
      pl_data_q <= pl_data_d;
      pl_row_q  <= pl_row_d;
      pl_col_q  <= pl_col_d;
    end
  end

  // Plane outputs are computed one cycle ahead so they appear registered
  // during the state that owns them.
  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    adv_d     = adv_q;
    pl_we_d   = 1'b0;
    pl_push_d = 1'b0;
    pl_data_d = pl_data_q;
    pl_row_d  = pl_row_q;
    pl_col_d  = pl_col_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_data)
            CHAR_NL: begin
              cur_col_d = '0;
              if (cur_row_q < LAST_ROW) begin
                cur_row_d = cur_row_q + 4'd1;
              end else begin
                state_d   = SCROLL;
                pl_we_d   = 1'b1;
                pl_push_d = 1'b1;
                pl_data_d = BLANK;
                pl_row_d  = LAST_ROW;
                pl_col_d  = '0;
              end
            end
            CHAR_BS: begin
`ifdef TERM_BACKSPACE_EN
              if (cur_col_q != '0) begin
                cur_col_d = cur_col_q - 6'd1;
                state_d   = WRITE;
                adv_d     = 1'b0;
                pl_we_d   = 1'b1;
                pl_data_d = BLANK;
                pl_row_d  = cur_row_q;
                pl_col_d  = cur_col_q - 6'd1;
              end else if (cur_row_q != '0) begin
                cur_row_d = cur_row_q - 4'd1;
                cur_col_d = LAST_COL;
                state_d   = WRITE;
                adv_d     = 1'b0;
                pl_we_d   = 1'b1;
                pl_data_d = BLANK;
                pl_row_d  = cur_row_q - 4'd1;
                pl_col_d  = LAST_COL;
              end
`else
              state_d = IDLE;
`endif
            end
            CHAR_FF: begin
              state_d   = CLEAR;
              cur_row_d = '0;
              cur_col_d = '0;
              pl_we_d   = 1'b1;
              pl_data_d = BLANK;
              pl_row_d  = '0;
              pl_col_d  = '0;
            end
            default: begin
              state_d   = WRITE;
              adv_d     = 1'b1;
              pl_we_d   = 1'b1;
              pl_data_d = in_data;
              pl_row_d  = cur_row_q;
              pl_col_d  = cur_col_q;
            end
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (adv_q) begin
          if (cur_col_q < LAST_COL) begin
            cur_col_d = cur_col_q + 6'd1;
          end else begin
            cur_col_d = '0;
            if (cur_row_q < LAST_ROW) begin
              cur_row_d = cur_row_q + 4'd1;
            end else begin
              state_d   = SCROLL;
              pl_we_d   = 1'b1;
              pl_push_d = 1'b1;
              pl_data_d = BLANK;
              pl_row_d  = LAST_ROW;
              pl_col_d  = '0;
            end
          end
        end
      end
      SCROLL: begin
        state_d = IDLE;
      end
      CLEAR: begin
        // The plane address itself is the sweep counter.
        if (pl_row_q == LAST_ROW && pl_col_q == LAST_COL) begin
          state_d = IDLE;
        end else begin
          pl_we_d   = 1'b1;
          pl_data_d = BLANK;
          if (pl_col_q == LAST_COL) begin
            pl_col_d = '0;
            pl_row_d = pl_row_q + 4'd1;
          end else begin
            pl_col_d = pl_col_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign plane_we      = pl_we_q;
  assign plane_push_up = pl_push_q;
  assign plane_data    = pl_data_q;
  assign plane_row     = pl_row_q;
  assign plane_col     = pl_col_q;
  assign cursor_row    = cur_row_q;
  assign cursor_col    = cur_col_q;

endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: directed stimulus for term_writer with a write-list model.
// Each accepted character expands in the model into the list of plane
// writes it must cause (one per cycle) and the final cursor; one compare
// process checks every cycle after reset against that list.
module tb_term_writer;

  localparam int         ROWS  = 15;
  localparam int         COLS  = 40;
  localparam logic [7:0] BLANK = 8'h00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] plane_data;
  logic [3:0] plane_row;
  logic [5:0] plane_col;
  logic       plane_we;
  logic       plane_push_up;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  term_writer #(.ROWS(ROWS), .COLS(COLS), .BLANK(BLANK)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .plane_data(plane_data), .plane_row(plane_row), .plane_col(plane_col),
    .plane_we(plane_we), .plane_push_up(plane_push_up),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       push;
    int         row;
    int         col;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  m_row = 0, m_col = 0;
  bit  cur_busy = 0, m_acc = 0, armed = 0;
  int  n_chk = 0, n_fail = 0;
  int  we_cnt = 0, push_cnt = 0, last_row = 0, last_col = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic push, input int r, input int c, input logic [7:0] d);
    wr_t w;
    w.push = push; w.row = r; w.col = c; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic model_char(input logic [7:0] ch);
    case (ch)
      8'h0A: begin
        m_col = 0;
        if (m_row < ROWS - 1) m_row++;
        else push_wr(1'b1, ROWS - 1, 0, BLANK);
      end
      8'h08: begin
`ifdef TERM_BACKSPACE_EN
        if (m_col > 0) begin
          m_col--;
          push_wr(1'b0, m_row, m_col, BLANK);
        end else if (m_row > 0) begin
          m_row--;
          m_col = COLS - 1;
          push_wr(1'b0, m_row, m_col, BLANK);
        end
`endif
      end
      8'h0C: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            push_wr(1'b0, r, c, BLANK);
        m_row = 0;
        m_col = 0;
      end
      default: begin
        push_wr(1'b0, m_row, m_col, ch);
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0;
          if (m_row < ROWS - 1) m_row++;
          else push_wr(1'b1, ROWS - 1, 0, BLANK);
        end
      end
    endcase
  endtask

  // Model: accept whenever the previous cycle carried no expected activity.
  always @(posedge clock) begin
    m_acc = 0;
    if (reset) begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      armed = 1;
    end else if (armed && in_valid && !cur_busy) begin
      m_acc = 1;
      model_char(in_data);
    end
  end

  // Compare: every cycle after the first reset edge.
  always @(negedge clock) begin
    if (armed) begin
      if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        cur_busy = 1;
        chk("write_cycle",
            {10'd0, plane_we, plane_push_up, busy, in_ready, plane_row, plane_col, plane_data},
            {10'd0, 1'b1, w.push, 1'b1, 1'b0, 4'(w.row), 6'(w.col), w.data});
      end else begin
        cur_busy = 0;
        chk("idle_cycle",
            {18'd0, plane_we, plane_push_up, busy, in_ready, cursor_row, cursor_col},
            {18'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(m_row), 6'(m_col)});
      end
      if (plane_we) begin
        we_cnt++;
        last_row = int'(plane_row);
        last_col = int'(plane_col);
      end
      if (plane_push_up) push_cnt++;
    end
  end

  task automatic send(input logic [7:0] ch);
    int k;
    @(negedge clock);
    in_data  = ch;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!m_acc && k < 5000);
    in_valid = 1'b0;
    if (!m_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while ((cur_busy || exp_q.size() > 0) && k < 5000);
    if (cur_busy) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, p0;
    // Reset values, with a character offered during reset that must be ignored.
    in_data  = 8'h51;
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_plane_data", plane_data, BLANK);
    chk("rst_plane_pos", {plane_row, plane_col}, 10'd0);
    chk("rst_we_busy", {plane_we, plane_push_up, busy}, 3'b000);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_no_accept", {in_ready, cursor_row, cursor_col, plane_we}, {1'b1, 4'd0, 6'd0, 1'b0});

    // Single printable character.
    send(8'h41);
    @(negedge clock); #1;
    chk("a_write", {plane_we, plane_push_up, plane_row, plane_col, plane_data},
        {1'b1, 1'b0, 4'd0, 6'd0, 8'h41});
    chk("a_ready_low", in_ready, 1'b0);
    @(negedge clock); #1;
    chk("a_ready_back", in_ready, 1'b1);
    chk("a_cursor", {cursor_row, cursor_col}, {4'd0, 6'd1});

    // A full line wraps to the next row without scrolling.
    do_reset();
    w0 = we_cnt; p0 = push_cnt;
    repeat (COLS) send(8'h42);
    wait_idle();
    chk("line_writes", we_cnt - w0, 40);
    chk("line_push", push_cnt - p0, 0);
    chk("line_cursor", {cursor_row, cursor_col}, {4'd1, 6'd0});

    // Newline on the last row scrolls.
    do_reset();
    repeat (ROWS - 1) send(8'h0A);
    repeat (5) send(8'h78);
    wait_idle();
    chk("pre_scroll_cursor", {cursor_row, cursor_col}, {4'd14, 6'd5});
    send(8'h0A);
    @(negedge clock); #1;
    chk("scroll_cycle", {plane_we, plane_push_up, plane_row, plane_col, plane_data},
        {1'b1, 1'b1, 4'd14, 6'd0, 8'h00});
    @(negedge clock); #1;
    chk("scroll_cursor", {in_ready, cursor_row, cursor_col}, {1'b1, 4'd14, 6'd0});

    // Writing the last cell of the last row also scrolls.
    p0 = push_cnt;
    repeat (COLS) send(8'h79);
    wait_idle();
    chk("wrap_scroll_push", push_cnt - p0, 1);
    chk("wrap_scroll_cursor", {cursor_row, cursor_col}, {4'd14, 6'd0});

    // Backspace.
    do_reset();
    repeat (3) send(8'h0A);
    send(8'h08);
    @(negedge clock); #1;
`ifdef TERM_BACKSPACE_EN
    chk("bs_wrap_write", {plane_we, plane_push_up, plane_row, plane_col, plane_data},
        {1'b1, 1'b0, 4'd2, 6'd39, BLANK});
    @(negedge clock); #1;
    chk("bs_wrap_cursor", {cursor_row, cursor_col}, {4'd2, 6'd39});
`else
    chk("bs_dropped", {plane_we, busy, cursor_row, cursor_col}, {1'b0, 1'b0, 4'd3, 6'd0});
`endif
    send(8'h61); send(8'h08); send(8'h62); send(8'h08); send(8'h08);
    wait_idle();
    do_reset();
    w0 = we_cnt;
    send(8'h08);
    @(negedge clock); #1;
    chk("bs_origin", {plane_we, in_ready, cursor_row, cursor_col}, {1'b0, 1'b1, 4'd0, 6'd0});
    wait_idle();
    chk("bs_origin_nowrite", we_cnt - w0, 0);

    // Mixed text.
    send(8'h48); send(8'h69); send(8'h0A); send(8'h7A); send(8'h0A); send(8'h0A);
    wait_idle();

    // Form feed clears the whole plane.
    w0 = we_cnt;
    send(8'h0C);
    wait_idle();
    chk("clear_writes", we_cnt - w0, ROWS * COLS);
    chk("clear_last", {last_row[3:0], last_col[5:0]}, {4'd14, 6'd39});
    chk("clear_done", {in_ready, cursor_row, cursor_col}, {1'b1, 4'd0, 6'd0});

    // Reset part-way through a clear.
    send(8'h31);
    send(8'h0C);
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("clear_abort", {plane_we, plane_push_up, cursor_row, cursor_col}, {1'b0, 1'b0, 4'd0, 6'd0});
    reset = 1'b0;
    @(negedge clock); #1;
    chk("clear_abort_ready", {in_ready, busy}, {1'b1, 1'b0});
    send(8'h43);
    wait_idle();
    chk("after_abort_cursor", {cursor_row, cursor_col}, {4'd0, 6'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
